// File: rtl/sub_bytes_seq.sv
// sub_bytes_seq: iterative AES SubBytes over LANES bytes per cycle; define SBOX_INV_EN to add inverse S-boxes.
package sub_bytes_pkg;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] s, r;
    s = x;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction
endpackage

module S_box (
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);
  import sub_bytes_pkg::*;
  logic [7:0] w_b;
  assign w_b = ginv(i_a);
  assign o_s = w_b ^ rotl(w_b, 1) ^ rotl(w_b, 2) ^ rotl(w_b, 3) ^ rotl(w_b, 4) ^ 8'h63;
endmodule

module inv_S_box (
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);
  import sub_bytes_pkg::*;
  assign o_s = ginv(rotl(i_a, 1) ^ rotl(i_a, 3) ^ rotl(i_a, 6) ^ 8'h05);
endmodule

module sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         inv,
  input  logic [127:0] state_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] state_out
);
  localparam int BEATS = 16 / LANES;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_st;
  logic [CW-1:0] r_cnt;
  logic [127:0] r_data, w_next;
  logic [7:0] w_cur [16];
  logic [7:0] w_in [LANES];
  logic [7:0] w_fwd [LANES];
  logic [7:0] w_sub [LANES];
  logic [3:0] w_base;
  logic w_last;
  assign w_base = 4'(int'(r_cnt) * LANES);
  assign w_last = r_cnt == CW'(BEATS - 1);
  for (genvar b = 0; b < 16; b++) begin : g_byte
    assign w_cur[b] = r_data[127-8*b -: 8];
  end
`ifdef SBOX_INV_EN
  logic r_mode;
  logic [7:0] w_rev [LANES];
`else
  logic w_unused_inv;
  assign w_unused_inv = inv;
`endif
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign w_in[j] = w_cur[w_base + 4'(j)];
    S_box u_fwd (.i_a(w_in[j]), .o_s(w_fwd[j]));
`ifdef SBOX_INV_EN
    inv_S_box u_rev (.i_a(w_in[j]), .o_s(w_rev[j]));
    assign w_sub[j] = r_mode ? w_rev[j] : w_fwd[j];
`else
    assign w_sub[j] = w_fwd[j];
`endif
  end
  always_comb begin
    w_next = r_data;
    for (int j = 0; j < LANES; j++) w_next[127-8*(int'(w_base)+j) -: 8] = w_sub[j];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st   <= IDLE;
      r_cnt  <= '0;
      r_data <= '0;
`ifdef SBOX_INV_EN
      r_mode <= 1'b0;
`endif
    end else begin
      case (r_st)
        IDLE: if (start) begin
          r_st   <= RUN;
          r_cnt  <= '0;
          r_data <= state_in;
`ifdef SBOX_INV_EN
          r_mode <= inv;
`endif
        end
        RUN: begin
          r_data <= w_next;
          r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
          r_st   <= w_last ? DONE : RUN;
        end
        default: r_st <= IDLE;
      endcase
    end
  end
  assign busy = r_st != IDLE;
  assign done = r_st == DONE;
  assign state_out = r_data;
endmodule

// File: tb/tb_sub_bytes_seq.sv
// tb_sub_bytes_seq: scoreboard bench for sub_bytes_seq with LANES=4.
module tb_sub_bytes_seq;
  localparam int LANES = 4;
  localparam int BEATS = 16 / LANES;
  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  logic clk = 0, rst = 1, start = 0, inv = 0;
  logic [127:0] state_in = '0, state_out, exp_cur = '0;
  logic busy, done;
  int cyc = 0, total = 0, bad = 0, last_done = -1, ndone = 0;
  bit cont = 0;
  typedef struct { logic [127:0] exp; int acc; } item_t;
  item_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sub_bytes_seq #(.LANES(LANES)) dut (
    .clk(clk), .rst(rst), .start(start), .inv(inv),
    .state_in(state_in), .busy(busy), .done(done), .state_out(state_out)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rep(input logic [7:0] b);
    return {16{b}};
  endfunction

  always @(negedge clk) begin : monitor
    item_t it;
    if (done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        it = q.pop_front();
        ndone++;
        chk("data", state_out, it.exp);
        chk("latency", 128'(cyc - it.acc), 128'(BEATS));
        if (cont && last_done >= 0) chk("period", 128'(cyc - last_done), 128'(BEATS + 2));
        last_done = cyc;
      end
    end
    if (start && !busy && !rst) q.push_back('{exp_cur, cyc + 1});
  end

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      chk("timeout", 128'(q.size()), 0);
      q.delete();
    end
    @(posedge clk) #1;
  endtask

  task automatic run_one(input logic [127:0] din, input logic [127:0] dexp, input logic iv);
    @(posedge clk) #1;
    for (int i = 0; i < 100 && busy; i++) @(posedge clk) #1;
    state_in = din;
    exp_cur = dexp;
    inv = iv;
    start = 1;
    @(posedge clk) #1;
    start = 0;
    drain();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", state_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 0;
    run_one(FIPS_IN, FIPS_OUT, 0);
    run_one(rep(8'h00), rep(8'h63), 0);
    run_one(rep(8'h23), rep(8'h26), 0);
    run_one(rep(8'h56), rep(8'hb1), 0);
    run_one(rep(8'hff), rep(8'h16), 0);
    run_one(rep(8'h53), rep(8'hed), 0);
`ifdef SBOX_INV_EN
    run_one(rep(8'h63), rep(8'h00), 1);
    run_one(rep(8'hed), rep(8'h53), 1);
`else
    run_one(rep(8'h63), rep(8'hfb), 1);
    run_one(rep(8'hed), rep(8'h55), 1);
`endif
    run_one(rep(8'h53), rep(8'hed), 0);
    // continuous start with state_in changing while busy
    cont = 1;
    last_done = -1;
    n0 = ndone;
    state_in = FIPS_IN;
    exp_cur = FIPS_OUT;
    start = 1;
    for (int i = 0; i < 3 * (BEATS + 2); i++) begin
      @(posedge clk) #1;
      if (busy) begin
        state_in = i[0] ? FIPS_IN : rep(8'h56);
        exp_cur = i[0] ? FIPS_OUT : rep(8'hb1);
      end
    end
    start = 0;
    drain();
    cont = 0;
    chk("hs_count", 128'(ndone - n0), 3);
    // reset at beat 1
    state_in = FIPS_IN;
    exp_cur = FIPS_OUT;
    start = 1;
    @(posedge clk) #1;
    start = 0;
    @(posedge clk) #2;
    rst = 1;
    #1;
    chk("abort_out", state_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < BEATS + 3; i++) begin
      @(negedge clk);
      chk("no_done", done, 0);
    end
    run_one(FIPS_IN, FIPS_OUT, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
